// File: rtl/mest_pro_ctrl.sv
// MEST Pro fetch/decode/issue sequencer: ROM fetch, 4x8 register file, execute handshake, retire.
// Optional return stack enabled by defining MEST_PRO_CTRL_LINK_STACK_EN (default: single link register).
module mest_pro_ctrl #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  output logic [PC_W-1:0]   o_pm_addr,
  input  logic [15:0]       i_pm_data,
  output logic              o_execute,
  output logic [3:0]        o_op_code,
  output logic [DATA_W-1:0] o_operand1,
  output logic [DATA_W-1:0] o_operand2,
  input  logic              i_exec_done,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_carry,
  input  logic              i_zero_flag,
  input  logic              i_jump,
  input  logic              i_return_pc,
  input  logic              i_end_of_code,
  output logic              o_carry_flag,
  output logic              o_zero_flag,
  output logic              o_busy,
  output logic              o_halted
);

  // state    | meaning
  // S_IDLE   | out of reset, waiting for i_start
  // S_FETCH  | PC on o_pm_addr, ROM read in flight
  // S_DECODE | ROM word valid, captured at edge with operands
  // S_EXEC   | one-cycle execute strobe
  // S_WAIT   | hold issue outputs until i_exec_done, retire at that edge
  // S_HALT   | end-of-code retired, waiting for i_start
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0]   pc, pc_inc, link_pop;
  logic [DATA_W-1:0] rf [4];
  logic [1:0]        rd_q;
  logic [7:0]        imm_q;
  logic              restart, retire, do_push;

  if (STACK_DEPTH < 1) begin : g_depth_check
    $error("STACK_DEPTH must be at least 1");
  end

  assign restart = ((state == S_IDLE) || (state == S_HALT)) && i_start;
  assign retire  = (state == S_WAIT) && i_exec_done;
  assign do_push = retire && !i_end_of_code && i_jump;
  assign pc_inc  = pc + PC_W'(1);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (i_start) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_DECODE;
      S_DECODE:       state_nxt = S_EXEC;
      S_EXEC:         state_nxt = S_WAIT;
      S_WAIT:         if (i_exec_done) state_nxt = i_end_of_code ? S_HALT : S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  assign o_pm_addr = pc;
  assign o_execute = (state == S_EXEC);
  assign o_busy    = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_EXEC)  || (state == S_WAIT);
  assign o_halted  = (state == S_HALT);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc           <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      o_carry_flag <= 1'b0;
      o_zero_flag  <= 1'b0;
      o_op_code    <= '0;
      o_operand1   <= '0;
      o_operand2   <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
    end else begin
      if (restart) pc <= '0;
      if (state == S_DECODE) begin
        o_op_code  <= i_pm_data[15:12];
        o_operand1 <= rf[i_pm_data[11:10]];
        o_operand2 <= rf[i_pm_data[9:8]];
        rd_q       <= i_pm_data[11:10];
        imm_q      <= i_pm_data[7:0];
      end
      // end-of-code leaves PC on the halting instruction
      if (retire && !i_end_of_code) begin
        if (i_jump) begin
          pc <= PC_W'(imm_q);
        end else if (i_return_pc) begin
          pc <= link_pop;
        end else begin
          pc <= pc_inc;
          if (!o_op_code[3]) begin
            rf[rd_q]     <= i_result;
            o_carry_flag <= i_carry;
            o_zero_flag  <= i_zero_flag;
          end else if (o_op_code == 4'd10) begin
            rf[rd_q] <= DATA_W'(imm_q);
          end
        end
      end
    end
  end

`ifdef MEST_PRO_CTRL_LINK_STACK_EN
  localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [PC_W-1:0]  stk [STACK_DEPTH];
  logic [SP_W-1:0]  sp, sp_inc, sp_dec;
  logic [CNT_W-1:0] cnt;
  logic             do_pop;

  assign do_pop   = retire && !i_end_of_code && !i_jump && i_return_pc;
  assign sp_inc   = (sp == SP_W'(STACK_DEPTH - 1)) ? '0 : sp + SP_W'(1);
  assign sp_dec   = (sp == '0) ? SP_W'(STACK_DEPTH - 1) : sp - SP_W'(1);
  assign link_pop = (cnt == '0) ? '0 : stk[sp_dec];

  // sp is the next write slot; a push when full overwrites the oldest entry
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
      sp  <= '0;
      cnt <= '0;
    end else if (do_push) begin
      stk[sp] <= pc_inc;
      sp      <= sp_inc;
      if (cnt != CNT_W'(STACK_DEPTH)) cnt <= cnt + CNT_W'(1);
    end else if (do_pop && (cnt != '0)) begin
      sp  <= sp_dec;
      cnt <= cnt - CNT_W'(1);
    end
  end
`else
  logic [PC_W-1:0] link_q;

  assign link_pop = link_q;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n)   link_q <= '0;
    else if (do_push) link_q <= pc_inc;
  end
`endif

endmodule

// File: tb/tb_mest_pro_ctrl.sv
// Bench for mest_pro_ctrl: instruction-level reference model checked every cycle plus directed literal checks.
module tb_mest_pro_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, done = 1'b0;
  logic [7:0]  pm_addr, op1, op2, result;
  logic [15:0] pm_data;
  logic [3:0]  op_code;
  logic        execute, carry_in, zero_in, jump, ret, eoc;
  logic        carry_f, zero_f, busy, halted;

  mest_pro_ctrl dut (
    .clk(clk), .i_reset_n(rst_n), .i_start(start), .o_pm_addr(pm_addr), .i_pm_data(pm_data),
    .o_execute(execute), .o_op_code(op_code), .o_operand1(op1), .o_operand2(op2),
    .i_exec_done(done), .i_result(result), .i_carry(carry_in), .i_zero_flag(zero_in),
    .i_jump(jump), .i_return_pc(ret), .i_end_of_code(eoc),
    .o_carry_flag(carry_f), .o_zero_flag(zero_f), .o_busy(busy), .o_halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) pm_data <= rom[pm_addr];

  // execute unit: {carry, zero, result}; non-ALU ops return junk that must be ignored
  function automatic logic [9:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a;
      4'd6: r = b;
      4'd7: r = ~a;
      default: return {1'b1, 1'b1, 8'hAA};
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  always_comb {carry_in, zero_in, result} = alu(op_code, op1, op2);
  assign jump = (op_code == 4'd8);
  assign ret  = (op_code == 4'd9);
  assign eoc  = (op_code == 4'd15);

  int exec_delay = 0;
  initial begin
    int cnt;
    bit pending;
    cnt = 0; pending = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin done = 0; pending = 0; end
      else if (execute) begin done = 0; pending = 1; cnt = exec_delay; end
      else if (done) done = 0;
      else if (pending) begin
        if (cnt == 0) begin done = 1; pending = 0; end
        else cnt--;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_F, M_D, M_E, M_W, M_HALT} mphase_t;
  mphase_t    mph = M_IDLE;
  logic [7:0] mrf [4];
  logic [7:0] mpc, e_op1, e_op2;
  logic [3:0] e_op;
  logic [15:0] m_ir;
  logic       mc, mz;
`ifdef MEST_PRO_CTRL_LINK_STACK_EN
  logic [7:0] m_stk [$];
`else
  logic [7:0] m_link;
`endif

  int cyc_checks = 0, cyc_errors = 0, lit_checks = 0, lit_errors = 0;
  logic [7:0] exec_pc [$], exec_op1 [$];
  logic       exec_c [$], exec_z [$];

  task automatic model_reset();
    mph = M_IDLE; mpc = 0; mc = 0; mz = 0; e_op = 0; e_op1 = 0; e_op2 = 0; m_ir = 0;
    for (int i = 0; i < 4; i++) mrf[i] = 0;
`ifdef MEST_PRO_CTRL_LINK_STACK_EN
    m_stk.delete();
`else
    m_link = 0;
`endif
  endtask

  task automatic model_retire();
    logic [3:0] op;
    logic [1:0] rd;
    logic [7:0] imm;
    op = m_ir[15:12]; rd = m_ir[11:10]; imm = m_ir[7:0];
    mph = M_F;
    if (op == 4'd15) mph = M_HALT;
    else if (op == 4'd8) begin
`ifdef MEST_PRO_CTRL_LINK_STACK_EN
      m_stk.push_back(mpc + 8'd1);
      if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
`else
      m_link = mpc + 8'd1;
`endif
      mpc = imm;
    end else if (op == 4'd9) begin
`ifdef MEST_PRO_CTRL_LINK_STACK_EN
      mpc = (m_stk.size() == 0) ? 8'h00 : m_stk.pop_back();
`else
      mpc = m_link;
`endif
    end else begin
      if (op < 4'd8) {mc, mz, mrf[rd]} = alu(op, e_op1, e_op2);
      else if (op == 4'd10) mrf[rd] = imm;
      mpc = mpc + 8'd1;
    end
  endtask

  initial begin
    bit s_start, s_done, s_rst;
    bit x_busy, x_halt, x_exec;
    model_reset();
    forever begin
      @(posedge clk);
      s_start = start; s_done = done; s_rst = rst_n;
      if (!s_rst) model_reset();
      else case (mph)
        M_IDLE, M_HALT: if (s_start) begin mph = M_F; mpc = 0; end
        M_F: mph = M_D;
        M_D: begin
          m_ir = rom[mpc];
          e_op = m_ir[15:12]; e_op1 = mrf[m_ir[11:10]]; e_op2 = mrf[m_ir[9:8]];
          mph = M_E;
        end
        M_E: mph = M_W;
        M_W: if (s_done) model_retire();
        default: mph = M_IDLE;
      endcase
      #1;
      x_busy = (mph == M_F) || (mph == M_D) || (mph == M_E) || (mph == M_W);
      x_halt = (mph == M_HALT);
      x_exec = (mph == M_E);
      cyc_checks++;
      if (busy !== x_busy || halted !== x_halt || execute !== x_exec || pm_addr !== mpc ||
          carry_f !== mc || zero_f !== mz || op_code !== e_op || op1 !== e_op1 || op2 !== e_op2) begin
        cyc_errors++;
        $display("FAIL cycle t=%0t got busy=%b halt=%b exe=%b pc=%h c=%b z=%b op=%h a=%h b=%h want busy=%b halt=%b exe=%b pc=%h c=%b z=%b op=%h a=%h b=%h",
                 $time, busy, halted, execute, pm_addr, carry_f, zero_f, op_code, op1, op2,
                 x_busy, x_halt, x_exec, mpc, mc, mz, e_op, e_op1, e_op2);
      end
      if (execute) begin
        exec_pc.push_back(pm_addr); exec_op1.push_back(op1);
        exec_c.push_back(carry_f);  exec_z.push_back(zero_f);
      end
    end
  end

  // ---------------- directed tests ----------------
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    lit_checks++;
    if (got !== want) begin
      lit_errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [15:0] qget(input logic [7:0] q [$], input int i);
    return (i < q.size()) ? {8'h00, q[i]} : 16'hDEAD;
  endfunction

  function automatic logic [15:0] bget(input logic q [$], input int i);
    return (i < q.size()) ? {15'h0, q[i]} : 16'hDEAD;
  endfunction

  task automatic load(input logic [15:0] words [$]);
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    for (int i = 0; i < words.size(); i++) rom[i] = words[i];
  endtask

  task automatic start_prog();
    exec_pc.delete(); exec_op1.delete(); exec_c.delete(); exec_z.delete();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic run_to_halt(input string name);
    int n;
    n = 0;
    while (!halted && n < 2000) begin @(negedge clk); n++; end
    chk({name, "_halt_timeout"}, {15'h0, halted}, 16'h1);
  endtask

  task automatic wait_exec_pc(input logic [7:0] pc_w);
    int n;
    n = 0;
    while (!(exec_pc.size() > 0 && exec_pc[exec_pc.size()-1] == pc_w) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("wait_exec_pc_timeout", {8'h0, (exec_pc.size() > 0) ? exec_pc[exec_pc.size()-1] : 8'hEE}, {8'h0, pc_w});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_halted", {15'h0, halted}, 16'h0);
    chk("rst_pc", {8'h0, pm_addr}, 16'h0000);
    chk("rst_op1", {8'h0, op1}, 16'h0000);

    // LDI R0,5; LDI R1,3; ADD R0,R1; OR R0,R0; END
    load('{16'hA005, 16'hA403, 16'h0100, 16'h3000, 16'hF000});
    start_prog(); run_to_halt("t1");
    chk("t1_issue4_op1", qget(exec_op1, 3), 16'h0008);
    chk("t1_carry", {15'h0, carry_f}, 16'h0);
    chk("t1_zero", {15'h0, zero_f}, 16'h0);
    chk("t1_halt_pc", {8'h0, pm_addr}, 16'h0004);

    // LDI R0,FF; LDI R1,1; ADD R0,R1; SUB R1,R1; OR R0,R0; END
    load('{16'hA0FF, 16'hA401, 16'h0100, 16'h1500, 16'h3000, 16'hF000});
    start_prog(); run_to_halt("t2");
    chk("t2_add_carry", bget(exec_c, 3), 16'h1);
    chk("t2_add_zero", bget(exec_z, 3), 16'h1);
    chk("t2_rf0", qget(exec_op1, 4), 16'h0000);
    chk("t2_sub_carry", bget(exec_c, 4), 16'h0);
    chk("t2_sub_zero", bget(exec_z, 4), 16'h1);

    // CALL 0x10 at 0x02, RET at 0x10
    load('{16'hA811, 16'hB000, 16'h8010, 16'hF000});
    rom[8'h10] = 16'h9000;
    start_prog(); run_to_halt("t3");
    chk("t3_pc_a", qget(exec_pc, 2), 16'h0002);
    chk("t3_pc_b", qget(exec_pc, 3), 16'h0010);
    chk("t3_pc_c", qget(exec_pc, 4), 16'h0003);

    // slow execute unit, plus a start pulse while busy
    exec_delay = 3;
    load('{16'hAC7E, 16'h0F00, 16'hF000});
    start_prog();
    repeat (8) @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    run_to_halt("t4");
    exec_delay = 0;
    chk("t4_exec_pulses", 16'(exec_pc.size()), 16'd3);
    chk("t4_add_op1", qget(exec_op1, 1), 16'h007E);
    chk("t4_carry", {15'h0, carry_f}, 16'h0);

    // halt at 0x07, then restart with rf preserved (R3 = 0xFC)
    load('{16'h3F00, 16'hB000, 16'hB000, 16'hB000, 16'hB000, 16'hB000, 16'hB000, 16'hF000});
    start_prog(); run_to_halt("t5");
    chk("t5_halted", {15'h0, halted}, 16'h1);
    chk("t5_busy", {15'h0, busy}, 16'h0);
    repeat (3) @(negedge clk);
    chk("t5_pc_hold", {8'h0, pm_addr}, 16'h0007);
    start_prog(); run_to_halt("t5b");
    chk("t5_restart_pc", qget(exec_pc, 0), 16'h0000);
    chk("t5_restart_rf", qget(exec_op1, 0), 16'h00FC);

    // PC wrap 0xFF -> 0x00
    load('{16'h80FE});
    rom[8'hFE] = 16'hB000; rom[8'hFF] = 16'hB000;
    start_prog();
    wait_exec_pc(8'hFF);
    rom[0] = 16'hF000;
    run_to_halt("t6");
    chk("t6_wrap", qget(exec_pc, 3), 16'h0000);

`ifdef MEST_PRO_CTRL_LINK_STACK_EN
    // five nested calls, five returns: four good addresses then 0x00
    load('{16'h8010});
    rom[8'h10] = 16'h8020; rom[8'h20] = 16'h8030; rom[8'h30] = 16'h8040; rom[8'h40] = 16'h8050;
    rom[8'h50] = 16'h9000; rom[8'h41] = 16'h9000; rom[8'h31] = 16'h9000;
    rom[8'h21] = 16'h9000; rom[8'h11] = 16'h9000;
    start_prog();
    wait_exec_pc(8'h00);
    rom[0] = 16'hF000;
    run_to_halt("t7");
    chk("t7_ret1", qget(exec_pc, 6), 16'h0041);
    chk("t7_ret4", qget(exec_pc, 9), 16'h0011);
    chk("t7_ret5", qget(exec_pc, 10), 16'h0000);
`endif

    // reset during WAIT of ADD R0,R1
    exec_delay = 6;
    load('{16'hA005, 16'hA403, 16'h0100, 16'hF000});
    start_prog();
    wait_exec_pc(8'h02);
    repeat (2) @(negedge clk);
    rst_n = 0; #1;
    chk("t8_rst_exec", {15'h0, execute}, 16'h0);
    chk("t8_rst_busy", {15'h0, busy}, 16'h0);
    @(negedge clk); rst_n = 1;
    repeat (5) @(negedge clk);
    chk("t8_no_fetch", {7'h0, busy, pm_addr}, 16'h0000);
    exec_delay = 0;
    load('{16'h3000, 16'hF000});
    start_prog(); run_to_halt("t8");
    chk("t8_rf0", qget(exec_op1, 0), 16'h0000);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", cyc_errors + lit_errors, cyc_checks + lit_checks);
    $finish;
  end
endmodule

// File: doc/mest_pro_ctrl.md
# mest_pro_ctrl

Fetch/decode/issue sequencer for the MEST Pro core, driving the execute unit from the issuing side. It fetches 16-bit instructions from a synchronous program ROM, reads a 4×8 register file, and presents op code and operands with a one-cycle execute strobe. It waits for the execute unit's done, then writes back the result and flags and redirects the PC on jump, return or end-of-code.

## Interface
- DATA_W, 8, register and operand width; the execute interface is fixed at 8.
- PC_W, 8, program counter and ROM address width.
- STACK_DEPTH, 4, return-stack entries; used only when MEST_PRO_CTRL_LINK_STACK_EN is defined.

- clk  in  1  clock.
- i_reset_n  in  1  reset, asynchronous, active-low; clock clk.
- i_start  in  1  start pulse; accepted only in IDLE or HALT.
- o_pm_addr  out  PC_W  ROM address (registered PC).
- i_pm_data  in  16  ROM data, valid one cycle after o_pm_addr.
- o_execute  out  1  execute strobe to the execute unit.
- o_op_code  out  4  op code, held from DECODE through WAIT.
- o_operand1 / o_operand2  out  DATA_W  each  rf[rd] / rf[rs], held with o_op_code.
- i_exec_done  in  1  execute unit done.
- i_result  in  DATA_W  execute result.
- i_carry, i_zero_flag  in  1  execute flags.
- i_jump, i_return_pc, i_end_of_code  in  1  execute control decodes.
- o_carry_flag, o_zero_flag  out  1  architectural flags.
- o_busy  out  1  high in FETCH/DECODE/EXEC/WAIT.
- o_halted  out  1  high in HALT.

## Operation
- Instruction format: [15:12] op, [11:10] rd (also operand1 source), [9:8] rs (operand2 source), [7:0] imm.
- Reset: PC=0, rf all 0x00, flags 0, o_op_code/o_operand1/o_operand2=0, o_execute=0, o_busy=0, o_halted=0, link/stack cleared, state IDLE.
- IDLE --i_start--> FETCH with PC=0. HALT --i_start--> FETCH with PC=0. Registers and flags are kept on restart.
- FETCH: o_pm_addr=PC. Go to DECODE.
- DECODE: at the edge, capture o_op_code=i_pm_data[15:12], o_operand1=rf[rd], o_operand2=rf[rs], and latch rd and imm. Go to EXEC.
- EXEC: o_execute=1 for exactly this cycle (combinational from state). Go to WAIT.
- WAIT: hold all issue outputs. While i_exec_done=0, stay in WAIT with no timeout. On i_exec_done=1, retire at that edge:
  - op 0–7: rf[rd]=i_result; o_carry_flag=i_carry; o_zero_flag=i_zero_flag; PC+1.
  - op 10 (LDI, local): rf[rd]=imm; flags unchanged; PC+1. The execute result is ignored.
  - i_jump (op 8, CALL): push PC+1 to link; PC=imm.
  - i_return_pc (op 9): PC=pop link.
  - i_end_of_code (op 15): go to HALT; PC unchanged.
  - ops 11–14: no writeback; PC+1.
  - After retire, next state is FETCH (HALT for op 15).
- PC arithmetic is modulo 2^PC_W: 0xFF+1 wraps to 0x00, with no error.
- i_start while busy is ignored.
- Asserting reset mid-instruction aborts it: outputs go to reset values immediately and the in-flight instruction has no writeback.

## Timing
- Four cycles per instruction with an execute unit that responds one cycle later: FETCH, DECODE, EXEC, WAIT.
- o_execute rises 2 cycles after entering FETCH.
- Retire edge is the first WAIT edge with i_exec_done=1.
- Flags and rf are updated at the retire edge and are visible to the next instruction's DECODE.
- o_busy drops the cycle after end-of-code retires; o_halted rises in that same cycle.

## Configuration
- MEST_PRO_CTRL_LINK_STACK_EN defined: STACK_DEPTH-entry circular return stack.
  - Push when full overwrites the oldest entry.
  - Pop when empty returns 0x00 and leaves the stack empty.
- Undefined: single link register (reset 0x00).
  - CALL overwrites it; return reads it and leaves it unchanged.
  - Nested calls return to the innermost site only.

## Test plan
- Program LDI R0,0x05; LDI R1,0x03; ADD R0,R1; OR R0,R0 -> 4th issue shows o_operand1=0x08, o_carry_flag=0, o_zero_flag=0.
- LDI R0,0xFF; LDI R1,0x01; ADD R0,R1 -> rf[0]=0x00, o_carry_flag=1, o_zero_flag=1. A following SUB R1,R1 leaves o_carry_flag=0, o_zero_flag=1.
- CALL 0x10 at PC 0x02; RET at 0x10 -> o_pm_addr sequence 0x02, 0x10, 0x03.
  - With macro: 5 nested calls followed by 5 returns -> 4 correct return addresses, then 0x00.
- Execute unit delays i_exec_done by 3 cycles -> o_op_code/o_operand1/o_operand2 stable through WAIT, o_execute pulses once, retire on the done cycle.
- op 15 at PC 0x07 -> o_halted=1, o_busy=0, o_pm_addr stays 0x07. i_start then fetches 0x00 with rf preserved.
- Reset asserted during WAIT of ADD R0,R1 -> rf[0]=0x00, state IDLE, o_execute=0. No fetch occurs until i_start.
